// File: rtl/led_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen_pkg
//  Description : Shared definitions for the LED pattern generator: waveform
//                mode encodings, output width, and the fraction-of-cycle
//                helper that places the green and blue channels at one and
//                two thirds of the phase circle.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pattern_gen_pkg;

  // Waveform selection, as driven on the top-level mode port.
  typedef enum logic [1:0] {
    MODE_TRI = 2'd0,
    MODE_SAW = 2'd1,
    MODE_SQR = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  // Width of each colour output, fixed by the strip driver.
  localparam int c_OUT_W = 8;

  // Returns (thirds * 2^(bits+1)) / 3 with integer division. The product is
  // formed before dividing so that two thirds is floor(2N/3), not 2*floor(N/3).
  function automatic int unsigned third_of_cycle(input int unsigned bits,
                                                 input int unsigned thirds);
    return (thirds << (bits + 1)) / 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen_wave_shaper.sv
`default_nettype none
// ============================================================================
//  Module      : wave_shaper
//  Description : Purely combinational mapping from a BITS+1 bit phase value
//                to a BITS bit brightness level for one colour channel.
//                The phase MSB selects the second half of the cycle; the
//                lower BITS bits are the position within that half.
//  Ports       : x     - in  BITS+1 : channel phase
//                mode  - in  2      : waveform (triangle/sawtooth/square/off)
//                level - out BITS   : brightness level
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_shaper
  import led_pattern_gen_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS:0]   x,
  input  mode_e           mode,
  output logic [BITS-1:0] level
);

  logic            w_upper_half;
  logic [BITS-1:0] w_pos;

  assign w_upper_half = x[BITS];
  assign w_pos        = x[BITS-1:0];

  always_comb begin
    level = '0;
    case (mode)
      // Rising through the first half, mirrored through the second half.
      MODE_TRI: level = w_upper_half ? ~w_pos : w_pos;
      // Full phase halved so one ramp spans the whole cycle.
      MODE_SAW: level = x[BITS:1];
      MODE_SQR: level = {BITS{w_upper_half}};
      MODE_OFF: level = '0;
      default:  level = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : Per-LED colour pattern generator answering the colour
//                request handshake of the ws2812c strip driver. A global
//                phase advances by a programmable rate every PRESCALE cycles;
//                each LED sees that phase plus an index-dependent offset, and
//                the three channels are spread a third of a cycle apart.
//                The driver's new_address is a synchronous level; its rising
//                edge is the request.
//  Ports       : clk          - in  1      : system clock
//                reset        - in  1      : asynchronous reset, active high
//                mode         - in  2      : 0 tri, 1 saw, 2 square, 3 off
//                rate         - in  4      : phase increment per step
//                address      - in  ADDR_W : LED index requested
//                new_address  - in  1      : request level from the driver
//                red_out      - out 8      : red level, registered
//                green_out    - out 8      : green level, registered
//                blue_out     - out 8      : blue level, registered
//                rgb_valid    - out 1      : pulse when colours update
//                frame_start  - out 1      : pulse on an address-0 request
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int BITS      = 8,
  parameter int PRESCALE  = 65536,
  parameter int LED_PHASE = 32,
  parameter int ADDR_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [3:0]         rate,
  input  logic [ADDR_W-1:0]  address,
  input  logic               new_address,
  output logic [c_OUT_W-1:0] red_out,
  output logic [c_OUT_W-1:0] green_out,
  output logic [c_OUT_W-1:0] blue_out,
  output logic               rgb_valid,
  output logic               frame_start
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                 c_PW          = BITS + 1;
  localparam int                 c_PRE_W       = $clog2(PRESCALE);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST    = c_PRE_W'(PRESCALE - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_ONE     = c_PRE_W'(1);
  localparam logic [c_PW-1:0]    c_THIRD       = c_PW'(third_of_cycle(BITS, 1));
  localparam logic [c_PW-1:0]    c_TWO_THIRD   = c_PW'(third_of_cycle(BITS, 2));
  localparam logic [31:0]        c_LED_PHASE_U = 32'(LED_PHASE);
  localparam logic [31:0]        c_NUM_LEDS_U  = 32'(NUM_LEDS);
  localparam int                 c_NUM_CH      = 3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_PRE_W-1:0] r_presc;
  logic [c_PW-1:0]    r_phase;
  logic               r_new_address_q;
  mode_e              r_mode;
  logic [3:0]         r_rate;
  logic [c_OUT_W-1:0] r_red;
  logic [c_OUT_W-1:0] r_green;
  logic [c_OUT_W-1:0] r_blue;
  logic               r_rgb_valid;
  logic               r_frame_start;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic               w_step;
  logic               w_req;
  logic               w_frame_req;
  logic               w_in_range;
  mode_e              w_mode_eff;
  logic [c_PW-1:0]    w_rate_ext;
  logic [c_PW-1:0]    w_led_off;
  logic [c_PW-1:0]    w_p;
  logic [c_PW-1:0]    w_chan_x   [c_NUM_CH];
  logic [BITS-1:0]    w_chan_lvl [c_NUM_CH];

  assign w_step      = (r_presc == c_PRE_LAST);
  assign w_req       = new_address & ~r_new_address_q;
  assign w_frame_req = w_req & (address == '0);
  assign w_in_range  = (32'(address) < c_NUM_LEDS_U);

  // An address-0 request opens a new frame, so it is served with the mode
  // being latched at that moment rather than the previous frame's mode.
  assign w_mode_eff  = w_frame_req ? mode_e'(mode) : r_mode;

  // Rate is resized to the phase width; arithmetic is modulo 2^(BITS+1).
  assign w_rate_ext  = c_PW'(r_rate);

  // Only the low c_PW bits of the index offset matter after the modulo.
  assign w_led_off   = c_PW'(32'(address) * c_LED_PHASE_U);
  assign w_p         = r_phase + w_led_off;

  assign w_chan_x[0] = w_p;
  assign w_chan_x[1] = w_p + c_THIRD;
  assign w_chan_x[2] = w_p + c_TWO_THIRD;

  for (genvar g = 0; g < c_NUM_CH; g++) begin : g_chan
    wave_shaper #(
      .BITS (BITS)
    ) u_wave_shaper (
      .x     (w_chan_x[g]),
      .mode  (w_mode_eff),
      .level (w_chan_lvl[g])
    );
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc         <= '0;
      r_phase         <= '0;
      r_new_address_q <= 1'b0;
      r_mode          <= MODE_OFF;
      r_rate          <= '0;
      r_red           <= '0;
      r_green         <= '0;
      r_blue          <= '0;
      r_rgb_valid     <= 1'b0;
      r_frame_start   <= 1'b0;
    end else begin
      r_new_address_q <= new_address;

      // Step fires on the wrap cycle, so its period is exactly PRESCALE.
      if (w_step) begin
        r_presc <= '0;
        r_phase <= r_phase + w_rate_ext;
      end else begin
        r_presc <= r_presc + c_PRE_ONE;
      end

      // Shadow the configuration at frame boundaries only.
      if (w_frame_req) begin
        r_mode <= mode_e'(mode);
        r_rate <= rate;
      end

      r_rgb_valid   <= w_req;
      r_frame_start <= w_frame_req;

      // Colours are taken from the pre-step phase even when a step lands on
      // the same edge; outputs otherwise hold their last value.
      if (w_req) begin
        if (w_in_range) begin
          r_red   <= c_OUT_W'(w_chan_lvl[0]);
          r_green <= c_OUT_W'(w_chan_lvl[1]);
          r_blue  <= c_OUT_W'(w_chan_lvl[2]);
        end else begin
          r_red   <= '0;
          r_green <= '0;
          r_blue  <= '0;
        end
      end
    end
  end

  assign red_out     = r_red;
  assign green_out   = r_green;
  assign blue_out    = r_blue;
  assign rgb_valid   = r_rgb_valid;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_gen
//  Description : Self-checking bench for led_pattern_gen with BITS=4,
//                PRESCALE=4, LED_PHASE=4. Two instances share all inputs:
//                one with 8 LEDs and one with 6 LEDs for the range check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

  localparam int BITS      = 4;
  localparam int PRESCALE  = 4;
  localparam int LED_PHASE = 4;
  localparam int PH_MOD    = 32;   // 2^(BITS+1)
  localparam int HALF      = 16;
  localparam int MAXL      = 15;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic [3:0] rate;
  logic [2:0] address;
  logic       new_address;

  logic [7:0] red, green, blue;
  logic       valid, frame;
  logic [7:0] red6, green6, blue6;
  logic       valid6, frame6;

  led_pattern_gen #(
    .NUM_LEDS (8), .BITS (BITS), .PRESCALE (PRESCALE), .LED_PHASE (LED_PHASE)
  ) dut (
    .clk (clk), .reset (reset), .mode (mode), .rate (rate),
    .address (address), .new_address (new_address),
    .red_out (red), .green_out (green), .blue_out (blue),
    .rgb_valid (valid), .frame_start (frame)
  );

  led_pattern_gen #(
    .NUM_LEDS (6), .BITS (BITS), .PRESCALE (PRESCALE), .LED_PHASE (LED_PHASE)
  ) dut6 (
    .clk (clk), .reset (reset), .mode (mode), .rate (rate),
    .address (address), .new_address (new_address),
    .red_out (red6), .green_out (green6), .blue_out (blue6),
    .rgb_valid (valid6), .frame_start (frame6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // --------------------------------------------------------------------------
  // Reference model: phase as an integer, stepping on every PRESCALE-th
  // cycle counted since reset release; levels from plain arithmetic.
  // --------------------------------------------------------------------------
  int m_cycles;
  int m_phase;
  int m_rate_sh = 0;
  int m_mode_sh = 3;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cycles <= 0;
      m_phase  <= 0;
    end else begin
      m_cycles <= m_cycles + 1;
      if ((m_cycles + 1) % PRESCALE == 0)
        m_phase <= (m_phase + m_rate_sh) % PH_MOD;
    end
  end

  function automatic int lvl(input int x, input int md);
    case (md)
      0:       return (x < HALF) ? x : (PH_MOD - 1 - x);
      1:       return x / 2;
      2:       return (x >= HALF) ? MAXL : 0;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Issues one request starting at a negedge; returns two negedges later.
  task automatic do_req(input int addr);
    int md, p, er, eg, eb;
    address     = 3'(addr);
    new_address = 1'b1;
    md = (addr == 0) ? int'(mode) : m_mode_sh;
    p  = (m_phase + addr * LED_PHASE) % PH_MOD;
    er = lvl(p, md);
    eg = lvl((p + PH_MOD / 3) % PH_MOD, md);
    eb = lvl((p + 2 * PH_MOD / 3) % PH_MOD, md);
    @(negedge clk);
    new_address = 1'b0;
    chk("red",   red,   er);
    chk("green", green, eg);
    chk("blue",  blue,  eb);
    chk("valid", valid, 1);
    chk("frame", frame, (addr == 0) ? 1 : 0);
    chk("red6",   red6,   (addr >= 6) ? 0 : er);
    chk("green6", green6, (addr >= 6) ? 0 : eg);
    chk("blue6",  blue6,  (addr >= 6) ? 0 : eb);
    chk("valid6", valid6, 1);
    if (addr == 0) begin
      m_mode_sh = int'(mode);
      m_rate_sh = int'(rate);
    end
    @(negedge clk);
    chk("valid_drop",  valid,  0);
    chk("valid6_drop", valid6, 0);
    chk("frame_drop",  frame,  0);
  endtask

  // Asynchronous reset asserted between edges, checked before any edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_red",   red,   0);
    chk("rst_green", green, 0);
    chk("rst_blue",  blue,  0);
    chk("rst_valid", valid, 0);
    chk("rst_frame", frame, 0);
    new_address = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_mode_sh = 3;
    m_rate_sh = 0;
  endtask

  typedef struct {
    int md;
    int addr;
    int r;
    int g;
    int b;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first, found;

    // Phase held at 0 (rate 0): p = addr*4, green +10, blue +21.
    tbl[0] = '{md: 0, addr: 0, r:  0, g: 10, b: 10};
    tbl[1] = '{md: 0, addr: 3, r: 12, g:  9, b:  1};
    tbl[2] = '{md: 0, addr: 5, r: 11, g:  1, b:  9};
    tbl[3] = '{md: 1, addr: 2, r:  4, g:  9, b: 14};
    tbl[4] = '{md: 1, addr: 7, r: 14, g:  3, b:  8};
    tbl[5] = '{md: 2, addr: 1, r:  0, g:  0, b: 15};
    tbl[6] = '{md: 2, addr: 4, r: 15, g: 15, b:  0};
    tbl[7] = '{md: 3, addr: 6, r:  0, g:  0, b:  0};

    reset       = 1'b1;
    mode        = 2'd0;
    rate        = 4'd0;
    address     = 3'd0;
    new_address = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_red",   red,   0);
    chk("init_green", green, 0);
    chk("init_blue",  blue,  0);
    chk("init_valid", valid, 0);
    chk("init_frame", frame, 0);
    reset = 1'b0;

    // Request before the first step with triangle, rate 1.
    mode = 2'd0;
    rate = 4'd1;
    do_req(0);
    chk("t1_red",   red,   0);
    chk("t1_green", green, 10);
    chk("t1_blue",  blue,  10);

    // Triangle sweep over a full phase cycle, one request per step.
    for (int i = 0; i < 33; i++) begin
      do_req(0);
      repeat (2) @(negedge clk);
    end

    // Held new_address yields exactly one pulse, one cycle after the rise.
    address     = 3'd2;
    new_address = 1'b1;
    pulses      = 0;
    first       = -1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 4) new_address = 1'b0;
      if (valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_first",  first,  0);
    // Maximum request rate: two requests two cycles apart.
    do_req(3);
    do_req(4);

    // Table of frozen-phase vectors.
    apply_reset();
    rate = 4'd0;
    for (int i = 0; i < 8; i++) begin
      mode = 2'(tbl[i].md);
      do_req(0);
      do_req(tbl[i].addr);
      chk("tbl_red",   red,   tbl[i].r);
      chk("tbl_green", green, tbl[i].g);
      chk("tbl_blue",  blue,  tbl[i].b);
    end
    mode = 2'd0;
    do_req(0);
    do_req(7);
    chk("range_red6",  red6,  0);
    chk("range_blue6", blue6, 0);

    // Mode change mid-frame stays shadowed until the next address 0.
    mode = 2'd0;
    rate = 4'd1;
    do_req(0);
    for (int a = 1; a < 8; a++) begin
      if (a == 3) mode = 2'd2;
      do_req(a);
    end
    do_req(0);
    chk("shadow_square", ((red == 8'd0) || (red == 8'd15)) ? 1 : 0, 1);

    // Request colliding with a step uses the pre-step phase.
    apply_reset();
    mode = 2'd1;
    rate = 4'd5;
    do_req(0);
    found = 0;
    for (int i = 0; i < 3 * PRESCALE; i++) begin
      if (m_phase == 5) begin found = 1; break; end
      @(negedge clk);
    end
    chk("coll_phase5_reached", found, 1);
    rate = 4'd3;
    do_req(0);
    found = 0;
    for (int i = 0; i < 2 * PRESCALE; i++) begin
      if ((m_cycles + 1) % PRESCALE == 0) begin found = 1; break; end
      @(negedge clk);
    end
    chk("coll_step_found", found, 1);
    do_req(0);
    chk("coll_red_pre", red, 2);
    do_req(0);
    chk("coll_red_post", red, 4);

    // Randomised traffic against the model, with one reset mid-run.
    for (int i = 0; i < 300; i++) begin
      int a;
      mode = 2'($urandom_range(0, 3));
      rate = 4'($urandom_range(0, 15));
      a    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 7));
      do_req(a);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 150) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
